// File: rtl/cvxif_result_buffer.sv
// ---------------------------------------------------------------------------
// cvxif_result_buffer
//
// In-order result queue between the coprocessor execute datapath and the
// CV-X-IF result interface. Each completed result is held in a circular
// buffer until the CPU accepts it with x_result_ready_i. Results whose
// instruction id is killed on the commit interface are marked and then
// purged from the head without ever being offered to the CPU.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   in_*                    result offered by the execute stage (valid/ready)
//   commit_*                commit interface; only kill commits matter here
//   x_result_*              head entry presented to the CPU (valid/ready)
//   stat_delivered_o        (CVXIF_RESULT_STATS_EN only) delivered results
//   stat_killed_o           (CVXIF_RESULT_STATS_EN only) purged results
//
// Configuration
//   CVXIF_RESULT_STATS_EN   adds the two 32-bit wrapping event counters.
// ---------------------------------------------------------------------------
module cvxif_result_buffer #(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 3,
    parameter int XLEN     = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [ID_WIDTH-1:0] in_id_i,
    input  logic [XLEN-1:0]     in_data_i,
    input  logic [4:0]          in_rd_i,
    input  logic                in_we_i,
    input  logic                in_exc_i,
    input  logic [5:0]          in_exccode_i,

    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,

    output logic                x_result_valid_o,
    input  logic                x_result_ready_i,
    output logic [ID_WIDTH-1:0] x_result_id_o,
    output logic [XLEN-1:0]     x_result_data_o,
    output logic [4:0]          x_result_rd_o,
    output logic                x_result_we_o,
    output logic                x_result_exc_o,
    output logic [5:0]          x_result_exccode_o
`ifdef CVXIF_RESULT_STATS_EN
    ,
    output logic [31:0]         stat_delivered_o,
    output logic [31:0]         stat_killed_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    // Entry storage
    logic [ID_WIDTH-1:0] id_q      [DEPTH];
    logic [XLEN-1:0]     data_q    [DEPTH];
    logic [4:0]          rd_q      [DEPTH];
    logic [5:0]          exccode_q [DEPTH];
    logic [DEPTH-1:0]    we_q;
    logic [DEPTH-1:0]    exc_q;

    // Per-entry status
    logic [DEPTH-1:0]    occ_q,    occ_d;
    logic [DEPTH-1:0]    killed_q, killed_d;

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q,  count_d;

    logic full;
    logic empty;
    logic head_killed;
    logic kill_ev;
    logic push;
    logic deliver;
    logic purge;
    logic pop;

    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign head_killed = killed_q[rd_ptr_q];
    assign kill_ev     = commit_valid_i & commit_kill_i;

    // Readiness only looks at the registered count, so a pop in the same
    // cycle does not free a slot for a push until the next cycle.
    assign in_ready_o  = ~full;
    assign push        = in_valid_i & ~full;

    assign x_result_valid_o = ~empty & ~head_killed;
    assign deliver          = x_result_valid_o & x_result_ready_i;
    assign purge            = ~empty & head_killed;
    assign pop              = deliver | purge;

    assign x_result_id_o      = id_q[rd_ptr_q];
    assign x_result_data_o    = data_q[rd_ptr_q];
    assign x_result_rd_o      = rd_q[rd_ptr_q];
    assign x_result_we_o      = we_q[rd_ptr_q] & x_result_valid_o;
    assign x_result_exc_o     = exc_q[rd_ptr_q];
    assign x_result_exccode_o = exccode_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally since DEPTH
    // is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Kill marking happens first, then pop and push override their own slot.
    // A head that is delivered in the same cycle it is killed is simply
    // popped, so delivery wins. The pushed slot can never be the popped slot
    // (push needs a free slot, pop needs an occupied one).
    always_comb begin
        occ_d    = occ_q;
        killed_d = killed_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_ev && occ_q[i] && (id_q[i] == commit_id_i)) begin
                killed_d[i] = 1'b1;
            end
            if (pop && (rd_ptr_q == PTR_W'(i))) begin
                occ_d[i]    = 1'b0;
                killed_d[i] = 1'b0;
            end
            if (push && (wr_ptr_q == PTR_W'(i))) begin
                occ_d[i]    = 1'b1;
                killed_d[i] = kill_ev && (in_id_i == commit_id_i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            occ_q    <= '0;
            killed_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            occ_q    <= occ_d;
            killed_q <= killed_d;
        end
    end

    // Payload is cleared on reset so the head fields read as zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]      <= '0;
                data_q[i]    <= '0;
                rd_q[i]      <= '0;
                exccode_q[i] <= '0;
            end
            we_q  <= '0;
            exc_q <= '0;
        end else if (push) begin
            id_q[wr_ptr_q]      <= in_id_i;
            data_q[wr_ptr_q]    <= in_data_i;
            rd_q[wr_ptr_q]      <= in_rd_i;
            exccode_q[wr_ptr_q] <= in_exccode_i;
            we_q[wr_ptr_q]      <= in_we_i;
            exc_q[wr_ptr_q]     <= in_exc_i;
        end
    end

`ifdef CVXIF_RESULT_STATS_EN
    logic [31:0] stat_delivered_q;
    logic [31:0] stat_killed_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_delivered_q <= '0;
            stat_killed_q    <= '0;
        end else begin
            if (deliver) begin
                stat_delivered_q <= stat_delivered_q + 32'd1;
            end
            if (purge) begin
                stat_killed_q <= stat_killed_q + 32'd1;
            end
        end
    end

    assign stat_delivered_o = stat_delivered_q;
    assign stat_killed_o    = stat_killed_q;
`endif

endmodule

// File: tb/tb_cvxif_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_cvxif_result_buffer
//
// Scoreboard bench: every accepted result is pushed to exp_q, kills mark
// queued entries, killed heads are dropped one per cycle, and each delivery
// is compared against the front of exp_q.
// ---------------------------------------------------------------------------
module tb_cvxif_result_buffer;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [2:0]  in_id_i = '0;
    logic [31:0] in_data_i = '0;
    logic [4:0]  in_rd_i = '0;
    logic        in_we_i = 1'b0;
    logic        in_exc_i = 1'b0;
    logic [5:0]  in_exccode_i = '0;
    logic        commit_valid_i = 1'b0;
    logic [2:0]  commit_id_i = '0;
    logic        commit_kill_i = 1'b0;
    logic        x_result_valid_o;
    logic        x_result_ready_i = 1'b0;
    logic [2:0]  x_result_id_o;
    logic [31:0] x_result_data_o;
    logic [4:0]  x_result_rd_o;
    logic        x_result_we_o;
    logic        x_result_exc_o;
    logic [5:0]  x_result_exccode_o;
`ifdef CVXIF_RESULT_STATS_EN
    logic [31:0] stat_delivered_o;
    logic [31:0] stat_killed_o;
`endif

    cvxif_result_buffer #(.DEPTH(DEPTH), .ID_WIDTH(3), .XLEN(32)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .in_valid_i         (in_valid_i),
        .in_ready_o         (in_ready_o),
        .in_id_i            (in_id_i),
        .in_data_i          (in_data_i),
        .in_rd_i            (in_rd_i),
        .in_we_i            (in_we_i),
        .in_exc_i           (in_exc_i),
        .in_exccode_i       (in_exccode_i),
        .commit_valid_i     (commit_valid_i),
        .commit_id_i        (commit_id_i),
        .commit_kill_i      (commit_kill_i),
        .x_result_valid_o   (x_result_valid_o),
        .x_result_ready_i   (x_result_ready_i),
        .x_result_id_o      (x_result_id_o),
        .x_result_data_o    (x_result_data_o),
        .x_result_rd_o      (x_result_rd_o),
        .x_result_we_o      (x_result_we_o),
        .x_result_exc_o     (x_result_exc_o),
        .x_result_exccode_o (x_result_exccode_o)
`ifdef CVXIF_RESULT_STATS_EN
        ,
        .stat_delivered_o   (stat_delivered_o),
        .stat_killed_o      (stat_killed_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [47:0] f;
        logic [2:0]  id;
        bit          killed;
    } ent_t;

    ent_t exp_q[$];
    ent_t ent;
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_delivered = 0;
    int   m_killed = 0;
    int   sz;

    logic        s_valid;
    logic [47:0] s_fields;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] pack_dut();
        return {x_result_id_o, x_result_data_o, x_result_rd_o,
                x_result_we_o, x_result_exc_o, x_result_exccode_o};
    endfunction

    // Per-cycle output checks and sampling away from the active edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            s_valid  = x_result_valid_o;
            s_fields = pack_dut();
            check("in_ready", 64'(in_ready_o), 64'(exp_q.size() < DEPTH));
            check("valid", 64'(x_result_valid_o),
                  64'((exp_q.size() > 0) && !exp_q[0].killed));
            if (!x_result_valid_o) begin
                check("we_gated", 64'(x_result_we_o), 64'd0);
            end
        end
    end

    // Reference queue update at each active edge.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            sz = exp_q.size();
            if (sz > 0 && exp_q[0].killed) begin
                void'(exp_q.pop_front());
                m_killed++;
            end else if (sz > 0 && x_result_ready_i) begin
                ent = exp_q.pop_front();
                check("deliver_valid", 64'(s_valid), 64'd1);
                check("deliver_fields", 64'(s_fields), 64'(ent.f));
                m_delivered++;
            end
            if (commit_valid_i && commit_kill_i) begin
                foreach (exp_q[k]) begin
                    if (exp_q[k].id == commit_id_i) exp_q[k].killed = 1'b1;
                end
            end
            if (in_valid_i && sz < DEPTH) begin
                ent.f  = {in_id_i, in_data_i, in_rd_i, in_we_i, in_exc_i, in_exccode_i};
                ent.id = in_id_i;
                ent.killed = commit_valid_i && commit_kill_i && (in_id_i == commit_id_i);
                exp_q.push_back(ent);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_in(input logic [2:0] id, input logic [31:0] data, input logic [4:0] rd,
                          input logic we, input logic exc, input logic [5:0] code);
        in_valid_i   = 1'b1;
        in_id_i      = id;
        in_data_i    = data;
        in_rd_i      = rd;
        in_we_i      = we;
        in_exc_i     = exc;
        in_exccode_i = code;
    endtask

    task automatic push(input logic [2:0] id, input logic [31:0] data);
        set_in(id, data, 5'(id + 3'd1), id[0], id[1], 6'(id) + 6'd8);
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic kill(input logic [2:0] id, input logic k);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = k;
        tick();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic check_stats(input string tag);
`ifdef CVXIF_RESULT_STATS_EN
        check({tag, "_stat_delivered"}, 64'(stat_delivered_o), 64'(m_delivered));
        check({tag, "_stat_killed"}, 64'(stat_killed_o), 64'(m_killed));
`else
        check({tag, "_idle_valid"}, 64'(x_result_valid_o), 64'd0);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_valid", 64'(x_result_valid_o), 64'd0);
        check("rst_fields", 64'(pack_dut()), 64'd0);
        rst_i = 1'b0;
        tick();

        // T1 basic path
        x_result_ready_i = 1'b1;
        set_in(3'd1, 32'h0000_0010, 5'd5, 1'b1, 1'b0, 6'd0);
        tick();
        in_valid_i = 1'b0;
        #3;
        check("t1_valid_next", 64'(x_result_valid_o), 64'd1);
        check("t1_fields", 64'(pack_dut()), {16'd0, 3'd1, 32'h10, 5'd5, 1'b1, 1'b0, 6'd0});
        tick();
        tick();
        check("t1_empty", 64'(x_result_valid_o), 64'd0);

        // T2 backpressure and full
        x_result_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push(3'(i), 32'hA000_0000 + 32'(i));
        check("t2_full", 64'(in_ready_o), 64'd0);
        push(3'd7, 32'hDEAD_BEEF);
        x_result_ready_i = 1'b1;
        repeat (6) tick();
        check_stats("t2");

        // T3 kill purge, plus a non-kill commit that must not matter
        x_result_ready_i = 1'b0;
        push(3'd2, 32'h2222);
        push(3'd3, 32'h3333);
        push(3'd4, 32'h4444);
        kill(3'd2, 1'b0);
        kill(3'd3, 1'b1);
        x_result_ready_i = 1'b1;
        repeat (5) tick();
        check_stats("t3");

        // T4 wrap-around back-to-back
        for (int i = 0; i < 11; i++) begin
            set_in(3'(i), 32'h4000_0000 + 32'(i * 7), 5'(i), i[0], 1'b0, 6'(i));
            tick();
        end
        in_valid_i = 1'b0;
        repeat (3) tick();

        // T5 simultaneous events
        x_result_ready_i = 1'b0;
        push(3'd5, 32'h5555);
        x_result_ready_i = 1'b1;
        kill(3'd5, 1'b1);
        x_result_ready_i = 1'b0;
        set_in(3'd6, 32'h6666, 5'd6, 1'b1, 1'b0, 6'd0);
        kill(3'd6, 1'b1);
        in_valid_i = 1'b0;
        push(3'd2, 32'h2020);
        x_result_ready_i = 1'b0;
        push(3'd3, 32'h3030);
        tick();
        kill(3'd3, 1'b1);
        repeat (2) tick();
        x_result_ready_i = 1'b1;
        repeat (6) tick();
        check_stats("t5");

        // T6 reset mid-stream
        x_result_ready_i = 1'b0;
        push(3'd1, 32'h1111);
        push(3'd2, 32'h2222);
        push(3'd3, 32'h3333);
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_valid", 64'(x_result_valid_o), 64'd0);
        check("t6_in_ready", 64'(in_ready_o), 64'd1);
        exp_q.delete();
        m_delivered = 0;
        m_killed = 0;
        x_result_ready_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        repeat (5) tick();
        check_stats("t6");
        check("final_valid", 64'(x_result_valid_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
